// File: rtl/bidirectional_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bidirectional_shift_reg_pkg
// Purpose  : Shared constants and helpers for the bidirectional shift
//            register slice: shift-direction encodings, default stage count
//            and the fill-counter width calculation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bidirectional_shift_reg_pkg;

  // Shift-direction encodings for the SHIFT_LEFT parameter of the top.
  // These carry a DIR_ infix so they never collide with the parameter name.
  localparam int SHIFT_DIR_RIGHT = 0;
  localparam int SHIFT_DIR_LEFT  = 1;

  // Default number of stages.
  localparam int DEFAULT_WIDTH = 4;

  // Legal stage-count range.
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : bidirectional_shift_reg_pkg
`default_nettype wire

// File: rtl/bidirectional_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : bidirectional_shift_reg_if
// Purpose  : Serial/parallel bus of the shift register.
// Ports    : s_in   - serial data in (driven by the master)
//            out    - serial data out from the end stage
//            q      - parallel view of the stages, bit 0 = LSB
//            filled - high once WIDTH shifts completed since reset
//            Modport master: the block feeding s_in and observing outputs.
//            Modport slave : the shift register itself.
// Revision : 1.0 - initial release
// ============================================================================
interface bidirectional_shift_reg_if
  import bidirectional_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             s_in;
  logic             out;
  logic [WIDTH-1:0] q;
  logic             filled;

  modport master (
    output s_in,
    input  out,
    input  q,
    input  filled
  );

  modport slave (
    input  s_in,
    output out,
    output q,
    output filled
  );

endinterface : bidirectional_shift_reg_if
`default_nettype wire

// File: rtl/bidirectional_shift_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear. Counts up by one
//            on each enabled edge and holds at MAX; it never wraps. Clear
//            has priority over increment.
// Ports    : clk     - clock, rising edge
//            clr_i   - synchronous clear, active high
//            inc_i   - increment request
//            count_o - current count, 0..MAX
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import bidirectional_shift_reg_pkg::*;
#(
  parameter int MAX = DEFAULT_WIDTH,
  parameter int CW  = cnt_width(MAX)
) (
  input  wire logic          clk,
  input  wire logic          clr_i,
  input  wire logic          inc_i,
  output logic [CW-1:0]      count_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  // Elaboration guards: a zero ceiling or a too-narrow count is meaningless.
  generate
    if (MAX < 1) begin : g_bad_max
      $fatal(1, "sat_counter: MAX must be at least 1");
    end
    if (CW < cnt_width(MAX)) begin : g_bad_cw
      $fatal(1, "sat_counter: CW too narrow to hold MAX");
    end
  endgenerate

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_C)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/bidirectional_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : bidirectional_shift_reg
// Purpose  : Free-running WIDTH-stage serial shift register with compile-time
//            direction. Every rising edge (reset low) one bit enters from
//            s_in and the bit at the far end is presented on out, forming a
//            fixed serial delay line. Parallel contents and a fill flag are
//            exported for observation.
// Ports    : clk    - sole clock, rising edge
//            reset  - synchronous, active-high; clears contents and fill count
//            bus    - slave modport: s_in in; out, q, filled out
// Params   : WIDTH      - stage count, 2..64
//            SHIFT_LEFT - 0: s_in enters MSB, out = LSB
//                         1: s_in enters LSB, out = MSB
// Revision : 1.0 - initial release
// ============================================================================
module bidirectional_shift_reg
  import bidirectional_shift_reg_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SHIFT_LEFT = SHIFT_DIR_RIGHT
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  bidirectional_shift_reg_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Elaboration-time parameter checks.
  generate
    if (WIDTH < MIN_WIDTH) begin : g_width_too_small
      $fatal(1, "bidirectional_shift_reg: WIDTH must be at least 2");
    end
    if (WIDTH > MAX_WIDTH) begin : g_width_too_large
      $fatal(1, "bidirectional_shift_reg: WIDTH must not exceed 64");
    end
    if ((SHIFT_LEFT != SHIFT_DIR_RIGHT) && (SHIFT_LEFT != SHIFT_DIR_LEFT)) begin : g_bad_dir
      $fatal(1, "bidirectional_shift_reg: SHIFT_LEFT must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             out_w;
  logic [CNT_W-1:0] fill_cnt;

  // Direction-selected next state and output tap. Only one branch exists
  // after elaboration, so q_d and out_w have a single driver.
  generate
    if (SHIFT_LEFT == SHIFT_DIR_LEFT) begin : g_left
      assign q_d   = {q_q[WIDTH-2:0], bus.s_in};
      assign out_w = q_q[WIDTH-1];
    end else begin : g_right
      assign q_d   = {bus.s_in, q_q[WIDTH-1:1]};
      assign out_w = q_q[0];
    end
  endgenerate

  // Reset wins over shifting; s_in is ignored on a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Every non-reset edge is a shift, so the counter increments unconditionally
  // and the clear handles reset.
  sat_counter #(
    .MAX (WIDTH),
    .CW  (CNT_W)
  ) u_fill_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .inc_i   (1'b1),
    .count_o (fill_cnt)
  );

  // All outputs derive from registers only; nothing from s_in reaches them
  // combinationally.
  assign bus.q      = q_q;
  assign bus.out    = out_w;
  assign bus.filled = (fill_cnt == CNT_W'(WIDTH));

endmodule : bidirectional_shift_reg
`default_nettype wire

// File: tb/tb_bidirectional_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bidirectional_shift_reg
// Purpose  : Self-checking bench for bidirectional_shift_reg. A right-shift
//            and a left-shift instance (WIDTH=4) share the same stimulus.
//            Expected values come from a bit-history model: the bit sampled
//            k shifts ago sits k stages from the entry end. Directed literal
//            values from the test plan are checked alongside.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bidirectional_shift_reg;
  import bidirectional_shift_reg_pkg::*;

  localparam int W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  bidirectional_shift_reg_if #(.WIDTH(W)) bus_r ();
  bidirectional_shift_reg_if #(.WIDTH(W)) bus_l ();

  bidirectional_shift_reg #(.WIDTH(W), .SHIFT_LEFT(SHIFT_DIR_RIGHT)) dut_r (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_r)
  );

  bidirectional_shift_reg #(.WIDTH(W), .SHIFT_LEFT(SHIFT_DIR_LEFT)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  typedef struct packed {
    logic [W-1:0] q_r;
    logic [W-1:0] q_l;
    logic         out_r;
    logic         out_l;
    logic         filled;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  logic  hist[$];   // most recent sampled bit at index 0
  int    shifts;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge and push the resulting expectation.
  task automatic model_push(input logic r, input logic s, input string tag);
    exp_t e;
    logic b;
    if (r) begin
      hist.delete();
      shifts = 0;
    end else begin
      hist.push_front(s);
      if (hist.size() > W) void'(hist.pop_back());
      if (shifts < W) shifts++;
    end
    e = '0;
    for (int k = 0; k < W; k++) begin
      b = (k < hist.size()) ? hist[k] : 1'b0;
      e.q_r[W-1-k] = b;
      e.q_l[k]     = b;
    end
    e.out_r  = e.q_r[0];
    e.out_l  = e.q_l[W-1];
    e.filled = (shifts == W);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive one edge worth of stimulus, then compare after the edge.
  task automatic step(input logic r, input logic s, input string tag);
    exp_t  e;
    string t;
    reset      = r;
    bus_r.s_in = s;
    bus_l.s_in = s;
    model_push(r, s, tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "/q_r"},    64'(bus_r.q),      64'(e.q_r));
    chk({t, "/q_l"},    64'(bus_l.q),      64'(e.q_l));
    chk({t, "/out_r"},  64'(bus_r.out),    64'(e.out_r));
    chk({t, "/out_l"},  64'(bus_l.out),    64'(e.out_l));
    chk({t, "/fill_r"}, 64'(bus_r.filled), 64'(e.filled));
    chk({t, "/fill_l"}, 64'(bus_l.filled), 64'(e.filled));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] lit_r [4];
    logic [W-1:0] lit_l [4];
    logic         seq   [4];
    logic         s;

    shifts     = 0;
    bus_r.s_in = 1'b1;
    bus_l.s_in = 1'b1;

    // Reset held three edges with s_in high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset");
    chk("reset/q_lit",      64'(bus_r.q),      64'(4'b0000));
    chk("reset/out_lit",    64'(bus_r.out),    64'(1'b0));
    chk("reset/filled_lit", 64'(bus_r.filled), 64'(1'b0));

    // Test-plan sequence 1,0,1,1 on both directions.
    seq   = '{1'b1, 1'b0, 1'b1, 1'b1};
    lit_r = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    lit_l = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, seq[i], "seq");
      chk("seq/q_r_lit",   64'(bus_r.q),      64'(lit_r[i]));
      chk("seq/q_l_lit",   64'(bus_l.q),      64'(lit_l[i]));
      chk("seq/out_r_lit", 64'(bus_r.out),    64'(i == 3));
      chk("seq/out_l_lit", 64'(bus_l.out),    64'(i == 3));
      chk("seq/fill_lit",  64'(bus_r.filled), 64'(i == 3));
    end

    // Single pulse: out_r high for exactly one cycle, W-1 edges later.
    step(1'b1, 1'b0, "pulse_rst");
    step(1'b0, 1'b1, "pulse");
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, "pulse_tail");
      chk("pulse/out_r_lit", 64'(bus_r.out), 64'(i == W - 1));
    end

    // Load all ones, then a one-edge reset mid-stream.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "load");
    chk("load/q_r_lit", 64'(bus_r.q), 64'(4'b1111));
    chk("load/q_l_lit", 64'(bus_l.q), 64'(4'b1111));
    step(1'b1, 1'b1, "midrst");
    chk("midrst/q_lit",    64'(bus_r.q),      64'(4'b0000));
    chk("midrst/fill_lit", 64'(bus_r.filled), 64'(1'b0));
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, "refill");
      chk("refill/fill_lit", 64'(bus_l.filled), 64'(i == 4));
    end

    // Saturation: 20 more shifts with random data; filled must never drop.
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(1, 0));
      step(1'b0, s, "sat");
      chk("sat/fill_lit", 64'(bus_r.filled), 64'(1'b1));
    end

    // Reset held across several edges keeps everything cleared.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, "hold_rst");
      chk("hold_rst/q_l_lit", 64'(bus_l.q), 64'(4'b0000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bidirectional_shift_reg
`default_nettype wire
